// File: rtl/bcd_score_counter_if.sv
// Score counter bus: game-side controls in, BCD digit bus and flags out to the display drivers.
interface bcd_score_counter_if #(parameter int DIGITS = 3);
  logic                  enable;
  logic                  incr;
  logic                  clear;
  logic                  game_over;
  logic [4*DIGITS-1:0]   score_bcd;
  logic [4*DIGITS-1:0]   hi_bcd;
  logic [DIGITS-1:0]     digit_blank;
  logic                  sat;
  logic                  wrap;

  modport master (
    output enable, incr, clear, game_over,
    input  score_bcd, hi_bcd, digit_blank, sat, wrap
  );

  modport slave (
    input  enable, incr, clear, game_over,
    output score_bcd, hi_bcd, digit_blank, sat, wrap
  );
endinterface

// File: rtl/bcd_score_counter.sv
// Multi-digit BCD score counter with rising-edge event detect, high-score latch,
// saturate/wrap overflow handling and leading-zero blank flags.
module bcd_digit_inc (
  input  logic [3:0] d,
  input  logic       cin,
  output logic [3:0] q,
  output logic       cout
);
  // d >= 9 also folds any out-of-range code back to 0 so the bus stays legal BCD
  assign cout = cin & (d >= 4'd9);
  assign q    = !cin ? d : (d >= 4'd9) ? 4'd0 : d + 4'd1;
endmodule

module bcd_score_counter #(
  parameter int DIGITS   = 3,
  parameter bit SATURATE = 1'b1
) (
  input  logic               clk,
  input  logic               reset_n,
  bcd_score_counter_if.slave bus
);
  localparam logic [4*DIGITS-1:0] ALL9 = {DIGITS{4'h9}};

  logic [DIGITS-1:0][3:0] score_q, hi_q, nxt;
  logic [DIGITS:0]        cy;
  logic                   incr_q, sat_q, wrap_q, ev;
  logic [DIGITS-1:0]      blank;
  logic [DIGITS:1]        zhi;

  assign cy[0] = 1'b1;
  assign ev    = bus.incr & ~incr_q & bus.enable;

  // Full ripple carry: cy[DIGITS] set means the score is currently all-9s
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    bcd_digit_inc u_inc (
      .d    (score_q[i]),
      .cin  (cy[i]),
      .q    (nxt[i]),
      .cout (cy[i+1])
    );
  end

  // zhi[i]: digit i and every digit above it are zero
  assign zhi[DIGITS] = (score_q[DIGITS-1] == 4'd0);
  for (genvar i = DIGITS - 1; i >= 1; i--) begin : g_blank
    if (i < DIGITS - 1) begin : g_mid
      assign zhi[i] = zhi[i+1] & (score_q[i] == 4'd0);
    end else begin : g_top
      assign zhi[i] = zhi[DIGITS];
    end
    assign blank[i] = zhi[i];
  end
  assign blank[0] = 1'b0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      score_q <= '0;
      hi_q    <= '0;
      sat_q   <= 1'b0;
      wrap_q  <= 1'b0;
      incr_q  <= 1'b1;
    end else begin
      incr_q <= bus.incr;
      wrap_q <= 1'b0;
      // high score commits from the pre-edge score, independent of clear/event
      if (bus.game_over && (score_q > hi_q))
        hi_q <= score_q;
      if (bus.clear) begin
        score_q <= '0;
        sat_q   <= 1'b0;
      end else if (ev) begin
        if (cy[DIGITS]) begin
          if (SATURATE) begin
            sat_q <= 1'b1;
          end else begin
            score_q <= '0;
            wrap_q  <= 1'b1;
          end
        end else begin
          score_q <= nxt;
          if (SATURATE && (nxt == ALL9))
            sat_q <= 1'b1;
        end
      end
    end
  end

  assign bus.score_bcd   = score_q;
  assign bus.hi_bcd      = hi_q;
  assign bus.digit_blank = blank;
  assign bus.sat         = sat_q;
  assign bus.wrap        = wrap_q;
endmodule

// File: tb/tb_bcd_score_counter.sv
// Directed bench: a saturating and a wrapping counter driven in lockstep by the same inputs.
module tb_bcd_score_counter;
  logic clk, reset_n;
  logic enable, incr, clear, game_over;
  int   total = 0, bad = 0;

  bcd_score_counter_if #(.DIGITS(3)) bs ();
  bcd_score_counter_if #(.DIGITS(3)) bw ();

  assign bs.enable = enable;  assign bw.enable = enable;
  assign bs.incr = incr;      assign bw.incr = incr;
  assign bs.clear = clear;    assign bw.clear = clear;
  assign bs.game_over = game_over;  assign bw.game_over = game_over;

  bcd_score_counter #(.DIGITS(3), .SATURATE(1'b1)) u_sat (.clk(clk), .reset_n(reset_n), .bus(bs));
  bcd_score_counter #(.DIGITS(3), .SATURATE(1'b0)) u_wrp (.clk(clk), .reset_n(reset_n), .bus(bw));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        incr, en, clr, go;
    logic [11:0] score, hi;
    logic [2:0]  blank;
  } vec_t;
  vec_t tbl[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // score, hi and blank on both counters (only valid while below overflow)
  task automatic chk_both(input string nm, input logic [11:0] sc, input logic [11:0] hi,
                          input logic [2:0] bl);
    chk({nm, " s.score"}, 32'(bs.score_bcd), 32'(sc));
    chk({nm, " w.score"}, 32'(bw.score_bcd), 32'(sc));
    chk({nm, " s.hi"},    32'(bs.hi_bcd),    32'(hi));
    chk({nm, " w.hi"},    32'(bw.hi_bcd),    32'(hi));
    chk({nm, " blank"},   32'(bs.digit_blank), 32'(bl));
    chk({nm, " w.blank"}, 32'(bw.digit_blank), 32'(bl));
  endtask

  task automatic pulse(input int n);
    for (int k = 0; k < n; k++) begin
      incr = 1'b1; tick();
      incr = 1'b0; tick();
    end
  endtask

  task automatic do_clear();
    clear = 1'b1; tick();
    clear = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b1; incr = 1'b1; clear = 1'b0; game_over = 1'b0;

    // row: incr en clr go | score hi blank (starting from score 000, hi 000, incr_q=0)
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 12'h001, 12'h000, 3'b110};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 12'h001, 12'h000, 3'b110};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 12'h001, 12'h000, 3'b110};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h001, 12'h000, 3'b110};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 12'h001, 12'h000, 3'b110};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 12'h001, 12'h000, 3'b110};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h001, 12'h000, 3'b110};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 12'h002, 12'h000, 3'b110};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h002, 12'h000, 3'b110};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 12'h003, 12'h002, 3'b110};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h003, 12'h002, 3'b110};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 12'h000, 12'h002, 3'b110};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 12'h000, 12'h002, 3'b110};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 12'h001, 12'h002, 3'b110};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b1, 12'h001, 12'h002, 3'b110};
    tbl[15] = '{1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 12'h002, 3'b110};

    // T1: reset with incr held high; held incr after release is not an event
    tick(); tick();
    chk_both("reset", 12'h000, 12'h000, 3'b110);
    chk("reset s.sat", 32'(bs.sat), 32'd0);
    chk("reset w.wrap", 32'(bw.wrap), 32'd0);
    reset_n = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    chk_both("held incr", 12'h000, 12'h000, 3'b110);
    incr = 1'b0; tick();

    for (int i = 0; i < 16; i++) begin
      incr = tbl[i].incr; enable = tbl[i].en; clear = tbl[i].clr; game_over = tbl[i].go;
      tick();
      chk_both($sformatf("vec%0d", i), tbl[i].score, tbl[i].hi, tbl[i].blank);
    end
    incr = 1'b0; enable = 1'b1; clear = 1'b0; game_over = 1'b0;
    tick();

    // T2: ten pulses
    pulse(10);
    chk_both("ten", 12'h010, 12'h002, 3'b100);

    // T3: carries settle in the same cycle as the event
    do_clear(); pulse(99);
    chk_both("pre099", 12'h099, 12'h002, 3'b100);
    incr = 1'b1; tick();
    chk_both("099+1", 12'h100, 12'h002, 3'b000);
    incr = 1'b0; tick();
    do_clear(); pulse(199);
    incr = 1'b1; tick();
    chk_both("199+1", 12'h200, 12'h002, 3'b000);
    incr = 1'b0; tick();

    // T4: overflow
    do_clear(); pulse(998);
    chk("998 s.sat", 32'(bs.sat), 32'd0);
    pulse(1);
    chk_both("999", 12'h999, 12'h002, 3'b000);
    chk("999 s.sat", 32'(bs.sat), 32'd1);
    chk("999 w.sat", 32'(bw.sat), 32'd0);
    incr = 1'b1; tick();
    chk("ovf s.score", 32'(bs.score_bcd), 32'h999);
    chk("ovf s.sat", 32'(bs.sat), 32'd1);
    chk("ovf s.wrap", 32'(bs.wrap), 32'd0);
    chk("ovf w.score", 32'(bw.score_bcd), 32'h000);
    chk("ovf w.wrap", 32'(bw.wrap), 32'd1);
    chk("ovf w.sat", 32'(bw.sat), 32'd0);
    incr = 1'b0; tick();
    chk("ovf+1 w.wrap", 32'(bw.wrap), 32'd0);
    chk("ovf+1 s.sat", 32'(bs.sat), 32'd1);
    do_clear(); #0;
    chk("clr s.score", 32'(bs.score_bcd), 32'h000);
    chk("clr s.sat", 32'(bs.sat), 32'd0);

    // T5: high score
    pulse(42);
    game_over = 1'b1; tick(); game_over = 1'b0;
    chk_both("hi042", 12'h042, 12'h042, 3'b100);
    do_clear(); pulse(17);
    game_over = 1'b1; tick(); game_over = 1'b0;
    chk_both("hi kept", 12'h017, 12'h042, 3'b100);
    do_clear(); pulse(50);
    game_over = 1'b1; clear = 1'b1; tick(); game_over = 1'b0; clear = 1'b0;
    chk_both("go+clr", 12'h000, 12'h050, 3'b110);

    // T6: clear beats a same-cycle event; reset mid-count
    pulse(5);
    incr = 1'b1; clear = 1'b1; tick(); clear = 1'b0;
    chk_both("ev+clr", 12'h000, 12'h050, 3'b110);
    incr = 1'b0; tick();
    pulse(456);
    game_over = 1'b1; tick(); game_over = 1'b0;
    do_clear(); pulse(123);
    chk_both("pre rst", 12'h123, 12'h456, 3'b000);
    reset_n = 1'b0; tick();
    chk_both("mid rst", 12'h000, 12'h000, 3'b110);
    chk("mid rst s.sat", 32'(bs.sat), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
